// File: rtl/aes_pkg.sv
// Shared AES constants, state encoding and GF(2^8) helpers.
// Used by the key schedule, SubWord and S-box.
package aes_pkg;

  localparam int AES_NK = 4;
  localparam int AES_NR = 10;

  localparam logic [7:0] RCON_INIT = 8'h01;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_READY  = 2'd2;

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(
    input logic [31:0] w
  );
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0
  function automatic logic [7:0] gf_inv(
    input logic [7:0] a
  );
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// 32-bit SubWord from four S-boxes; reusable by
// wider AES key schedules.
module aes_sub_word (
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  for (genvar g = 0; g < 4; g++) begin : g_sb
    sbox u_sbox (
      .i_byte (i_word[8*g +: 8]),
      .o_byte (o_word[8*g +: 8])
    );
  end

endmodule

// File: rtl/sbox.sv
// Combinational AES forward S-box:
// GF(2^8) inverse followed by the affine transform.
module sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  logic [7:0] w_inv;

  assign w_inv  = gf_inv(i_byte);
  assign o_byte = w_inv
                ^ {w_inv[6:0], w_inv[7]}
                ^ {w_inv[5:0], w_inv[7:6]}
                ^ {w_inv[4:0], w_inv[7:5]}
                ^ {w_inv[3:0], w_inv[7:4]}
                ^ 8'h63;

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule with 11-entry round-key file.
// `define AES_KEY_STREAM_EN to export each key as it is written.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10,
  parameter int ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid_in,
  input  logic [127:0]      key_in,
  output logic              key_ready_out,
  output logic              keys_valid_out,
  input  logic [ADDR_W-1:0] rk_addr_in,
  output logic [127:0]      rk_out
`ifdef AES_KEY_STREAM_EN
  ,
  output logic              rk_stream_valid_out,
  output logic [3:0]        rk_stream_idx_out,
  output logic [127:0]      rk_stream_out
`endif
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_ROUNDS);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_round;
  logic [7:0]        r_rcon;
  logic [127:0]      r_rk [0:NUM_ROUNDS];

  logic         w_accept;
  logic [127:0] w_prev;
  logic [127:0] w_next;
  logic [31:0]  w_rot;
  logic [31:0]  w_sub;
  logic [31:0]  w_t;
  logic [31:0]  w_w0;
  logic [31:0]  w_w1;
  logic [31:0]  w_w2;
  logic [31:0]  w_w3;

  assign key_ready_out  = (r_state != ST_EXPAND);
  assign keys_valid_out = (r_state == ST_READY);
  assign w_accept       = key_valid_in && key_ready_out;

  assign w_prev = r_rk[r_round - ONE];
  assign w_rot  = rot_word(w_prev[31:0]);

  aes_sub_word u_sub_word (
    .i_word (w_rot),
    .o_word (w_sub)
  );

  assign w_t    = w_sub ^ {r_rcon, 24'h0};
  assign w_w0   = w_prev[127:96] ^ w_t;
  assign w_w1   = w_prev[95:64]  ^ w_w0;
  assign w_w2   = w_prev[63:32]  ^ w_w1;
  assign w_w3   = w_prev[31:0]   ^ w_w2;
  assign w_next = {w_w0, w_w1, w_w2, w_w3};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_round <= '0;
      r_rcon  <= RCON_INIT;
      rk_out  <= '0;
      for (int i = 0; i <= NUM_ROUNDS; i++)
        r_rk[i] <= '0;
    end else begin
      rk_out <= (rk_addr_in <= LAST) ? r_rk[rk_addr_in] : '0;
      if (w_accept) begin
        r_rk[0] <= key_in;
        r_round <= ONE;
        r_rcon  <= RCON_INIT;
        r_state <= ST_EXPAND;
      end else if (r_state == ST_EXPAND) begin
        r_rk[r_round] <= w_next;
        r_rcon        <= xtime(r_rcon);
        r_round       <= r_round + ONE;
        if (r_round == LAST)
          r_state <= ST_READY;
      end
    end
  end

`ifdef AES_KEY_STREAM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rk_stream_valid_out <= 1'b0;
      rk_stream_idx_out   <= '0;
      rk_stream_out       <= '0;
    end else if (w_accept) begin
      rk_stream_valid_out <= 1'b1;
      rk_stream_idx_out   <= '0;
      rk_stream_out       <= key_in;
    end else if (r_state == ST_EXPAND) begin
      rk_stream_valid_out <= 1'b1;
      rk_stream_idx_out   <= 4'(r_round);
      rk_stream_out       <= w_next;
    end else begin
      rk_stream_valid_out <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand against a
// word-oriented FIPS-197 key-expansion model.
module tb_aes_key_expand;

  logic         clk;
  logic         rst;
  logic         key_valid_in;
  logic [127:0] key_in;
  logic         key_ready_out;
  logic         keys_valid_out;
  logic [3:0]   rk_addr_in;
  logic [127:0] rk_out;
`ifdef AES_KEY_STREAM_EN
  logic         rk_stream_valid_out;
  logic [3:0]   rk_stream_idx_out;
  logic [127:0] rk_stream_out;
`endif

  aes_key_expand #(
    .NUM_ROUNDS (10),
    .ADDR_W     (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .key_valid_in   (key_valid_in),
    .key_in         (key_in),
    .key_ready_out  (key_ready_out),
    .keys_valid_out (keys_valid_out),
    .rk_addr_in     (rk_addr_in),
    .rk_out         (rk_out)
`ifdef AES_KEY_STREAM_EN
    ,
    .rk_stream_valid_out (rk_stream_valid_out),
    .rk_stream_idx_out   (rk_stream_idx_out),
    .rk_stream_out       (rk_stream_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] KEY_A1 =
    128'h2b7e151628aed2a6abf7158809cf4f3c;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]   sb [0:255];
  logic [127:0] exp_rk [0:10];

  task automatic chk(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // S-box table built by walking generator 3 and its inverse
  task automatic build_sbox();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]}
            ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  task automatic model(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++)
      w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]],
               sb[tmp[15:8]],  sb[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc  = (rc * 2) % 256 ^ ((rc >= 128) ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int j = 0; j < 11; j++)
      exp_rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
  endtask

  task automatic rd(
    input  logic [3:0]   a,
    output logic [127:0] v
  );
    rk_addr_in = a;
    @(negedge clk);
    v = rk_out;
  endtask

  task automatic run_key(
    input logic [127:0] k,
    input bit           noisy
  );
    model(k);
    @(negedge clk);
    key_in       = k;
    key_valid_in = 1'b1;
    @(negedge clk);
    key_valid_in = 1'b0;
    for (int n = 0; n <= 10; n++) begin
      if (n < 10) begin
        chk("ready_low", key_ready_out, 0);
        chk("valid_low", keys_valid_out, 0);
      end else begin
        chk("ready_high", key_ready_out, 1);
        chk("valid_high", keys_valid_out, 1);
      end
`ifdef AES_KEY_STREAM_EN
      chk("strm_vld", rk_stream_valid_out, 1);
      chk("strm_idx", rk_stream_idx_out, n);
      chk("strm_key", rk_stream_out, exp_rk[n]);
`endif
      if (noisy && n < 10) begin
        key_valid_in = 1'b1;
        key_in = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        key_valid_in = 1'b0;
      end
      if (n < 10) @(negedge clk);
    end
`ifdef AES_KEY_STREAM_EN
    @(negedge clk);
    chk("strm_end", rk_stream_valid_out, 0);
`endif
  endtask

  task automatic verify_all(input string tag);
    logic [127:0] v;
    for (int a = 0; a <= 10; a++) begin
      rd(4'(a), v);
      chk($sformatf("%s_rk%0d", tag, a), v, exp_rk[a]);
    end
  endtask

  initial begin
    logic [127:0] v;
    logic [127:0] k2;
    build_sbox();
    rst          = 1'b1;
    key_valid_in = 1'b0;
    key_in       = '0;
    rk_addr_in   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", key_ready_out, 1);
    chk("rst_valid", keys_valid_out, 0);
    chk("rst_rkout", rk_out, 0);

    run_key(KEY_A1, 1'b1);
    verify_all("a1");
    rd(4'd0, v);
    chk("a1_gold0", v, KEY_A1);
    rd(4'd1, v);
    chk("a1_gold1", v, 128'ha0fafe1788542cb123a339392a6c7605);
    rd(4'd10, v);
    chk("a1_gold10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    run_key('0, 1'b0);
    verify_all("zero");
    rd(4'd1, v);
    chk("z_gold1", v, 128'h62636363626363636263636362636363);
    rd(4'd10, v);
    chk("z_gold10", v, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    for (int t = 0; t < 3; t++) begin
      k2 = {$urandom, $urandom, $urandom, $urandom};
      run_key(k2, t[0]);
      verify_all($sformatf("rnd%0d", t));
    end
    rd(4'd15, v);
    chk("addr15", v, 0);
    rd(4'd11, v);
    chk("addr11", v, 0);

    @(negedge clk);
    key_in       = KEY_A1;
    key_valid_in = 1'b1;
    @(negedge clk);
    key_valid_in = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy", key_ready_out, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_ready", key_ready_out, 1);
    chk("mid_valid", keys_valid_out, 0);
    chk("mid_rkout", rk_out, 0);
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), v);
      chk($sformatf("mid_clr%0d", a), v, 0);
    end

    run_key(KEY_A1, 1'b0);
    verify_all("a1b");
    rd(4'd10, v);
    chk("a1b_gold10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
